// File: rtl/food_placer.sv
// Food placer: reduces LFSR X/Y words modulo the grid, then queries the body store until a free cell is found.
// Optional FOOD_PLACER_SCAN_EN adds a linear scan of the grid after MAX_TRIES random candidates all hit.
module food_placer #(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int MAX_TRIES = 15
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic       req,
    input  logic [9:0] rnd_x,
    input  logic [9:0] rnd_y,
    output logic       occ_req,
    output logic [5:0] occ_x,
    output logic [5:0] occ_y,
    input  logic       occ_ack,
    input  logic       occ_hit,
    output logic [5:0] food_x,
    output logic [5:0] food_y,
    output logic       food_valid,
    output logic       fail,
    output logic       busy
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REDUCE   = 3'd1;
    localparam logic [2:0] S_QUERY    = 3'd2;
    localparam logic [2:0] S_RESAMPLE = 3'd3;
    localparam logic [2:0] S_FAIL     = 3'd4;
`ifdef FOOD_PLACER_SCAN_EN
    localparam logic [2:0]  S_SCAN      = 3'd5;
    localparam logic [2:0]  S_SCAN_NEXT = 3'd6;
    localparam logic [12:0] CELLS       = 13'(GRID_W * GRID_H);
`endif
    localparam logic [9:0] GW = 10'(GRID_W);
    localparam logic [9:0] GH = 10'(GRID_H);
    localparam logic [3:0] MT = 4'(MAX_TRIES);

    logic [2:0] state_q, state_d;
    logic [9:0] sx_q, sx_d, sy_q, sy_d;
    logic [3:0] tries_q, tries_d;
    logic [5:0] food_x_q, food_x_d, food_y_q, food_y_d;
    logic       food_valid_q, food_valid_d, fail_q, fail_d;
`ifdef FOOD_PLACER_SCAN_EN
    logic [12:0] scan_cnt_q, scan_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        tries_d      = tries_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        fail_d       = fail_q;
`ifdef FOOD_PLACER_SCAN_EN
        scan_cnt_d   = scan_cnt_q;
`endif
        case (state_q)
            S_IDLE: if (req) begin
                sx_d         = rnd_x;
                sy_d         = rnd_y;
                food_valid_d = 1'b0;
                fail_d       = 1'b0;
                tries_d      = 4'd0;
                state_d      = S_REDUCE;
            end
            // Range check precedes the subtract, so an in-range pair costs one extra edge.
            S_REDUCE: begin
                if (sx_q < GW && sy_q < GH) begin
                    state_d = S_QUERY;
                end else begin
                    if (sx_q >= GW) sx_d = sx_q - GW;
                    if (sy_q >= GH) sy_d = sy_q - GH;
                end
            end
            S_QUERY: if (occ_ack) begin
                if (!occ_hit) begin
                    food_x_d     = sx_q[5:0];
                    food_y_d     = sy_q[5:0];
                    food_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    tries_d = tries_q + 4'd1;
                    if (tries_q + 4'd1 < MT) begin
                        state_d = S_RESAMPLE;
                    end else begin
`ifdef FOOD_PLACER_SCAN_EN
                        scan_cnt_d = 13'd0;
                        state_d    = S_SCAN_NEXT;
`else
                        state_d    = S_FAIL;
`endif
                    end
                end
            end
            S_RESAMPLE: begin
                sx_d    = rnd_x;
                sy_d    = rnd_y;
                state_d = S_REDUCE;
            end
            S_FAIL: begin
                fail_d  = 1'b1;
                state_d = S_IDLE;
            end
`ifdef FOOD_PLACER_SCAN_EN
            S_SCAN: if (occ_ack) begin
                if (!occ_hit) begin
                    food_x_d     = sx_q[5:0];
                    food_y_d     = sy_q[5:0];
                    food_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    scan_cnt_d = scan_cnt_q + 13'd1;
                    state_d    = (scan_cnt_q + 13'd1 == CELLS) ? S_FAIL : S_SCAN_NEXT;
                end
            end
            // Advance raster-order with wrap; the step state keeps queries from running back-to-back.
            S_SCAN_NEXT: begin
                if (sx_q == GW - 10'd1) begin
                    sx_d = 10'd0;
                    sy_d = (sy_q == GH - 10'd1) ? 10'd0 : sy_q + 10'd1;
                end else begin
                    sx_d = sx_q + 10'd1;
                end
                state_d = S_SCAN;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sx_q         <= 10'd0;
            sy_q         <= 10'd0;
            tries_q      <= 4'd0;
            food_x_q     <= 6'd0;
            food_y_q     <= 6'd0;
            food_valid_q <= 1'b0;
            fail_q       <= 1'b0;
`ifdef FOOD_PLACER_SCAN_EN
            scan_cnt_q   <= 13'd0;
`endif
        end else begin
            state_q      <= state_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            tries_q      <= tries_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            fail_q       <= fail_d;
`ifdef FOOD_PLACER_SCAN_EN
            scan_cnt_q   <= scan_cnt_d;
`endif
        end
    end

`ifdef FOOD_PLACER_SCAN_EN
    assign occ_req = (state_q == S_QUERY) || (state_q == S_SCAN);
`else
    assign occ_req = (state_q == S_QUERY);
`endif
    assign occ_x      = occ_req ? sx_q[5:0] : 6'd0;
    assign occ_y      = occ_req ? sy_q[5:0] : 6'd0;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign fail       = fail_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_food_placer.sv
// Randomized bench for food_placer: a modulo/latency reference model drives the occupancy responder and checks every query and result.
module tb_food_placer;
    localparam int W  = 32;
    localparam int H  = 24;
    localparam int MT = 15;

    logic       clk1 = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [9:0] rnd_x = '0;
    logic [9:0] rnd_y = '0;
    logic       occ_ack = 1'b0;
    logic       occ_hit = 1'b0;
    logic       occ_req, food_valid, fail, busy;
    logic [5:0] occ_x, occ_y, food_x, food_y;
    int         checks = 0;
    int         failures = 0;

    always #5 clk1 = ~clk1;

    food_placer #(.GRID_W(W), .GRID_H(H), .MAX_TRIES(MT)) dut (
        .clk1(clk1), .rst_n(rst_n), .req(req), .rnd_x(rnd_x), .rnd_y(rnd_y),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .fail(fail), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_occ_req"}, occ_req, 0);
        chk({tag, "_occ_xy"}, {occ_x, occ_y}, 0);
        chk({tag, "_food_xy"}, {food_x, food_y}, 0);
        chk({tag, "_fv_fail"}, {food_valid, fail}, 0);
    endtask

    // mode 0: first nhits queries hit, then miss; mode 1: only cell (5,3) is free.
    task automatic place(input int rx, input int ry, input int nhits, input int dly,
                         input int mode, input bit pulse_busy);
        int  ex, ey, exp_lat, cyc, q;
        bit  hit, done;
        rnd_x = 10'(rx); rnd_y = 10'(ry); req = 1'b1;
        tick();
        req = 1'b0;
        chk("busy_after_req", busy, 1);
        chk("fv_cleared", {food_valid, fail}, 0);
        ex = rx % W; ey = ry % H;
        exp_lat = max2(rx / W, ry / H) + 1;
        cyc = 0; q = 0; done = 0;
        req = pulse_busy;
        rnd_x = 10'($urandom_range(0, 1023));
        while (!done && q < 2000) begin
            while (!occ_req && cyc < 200) begin
                tick();
                req = 1'b0;
                cyc++;
            end
            if (!occ_req) begin
                chk("occ_req_timeout", 0, 1);
                return;
            end
            if (mode == 0) begin
                chk("query_latency", cyc, exp_lat);
                chk("occ_x", occ_x, ex);
                chk("occ_y", occ_y, ey);
            end
            for (int d = 0; d < dly; d++) begin
                tick();
                if (mode == 0) begin
                    chk("hold_req", occ_req, 1);
                    chk("hold_xy", {occ_x, occ_y}, {6'(ex), 6'(ey)});
                end
            end
            hit = (mode == 0) ? (q < nhits) : !(occ_x == 6'd5 && occ_y == 6'd3);
            occ_ack = 1'b1; occ_hit = hit; q++;
            tick();
            occ_ack = 1'b0; occ_hit = 1'b0;
            chk("req_drop", occ_req, 0);
            if (!hit) begin
                chk("food_valid", food_valid, 1);
                chk("food_x", food_x, (mode != 0) ? 5 : ex);
                chk("food_y", food_y, (mode != 0) ? 3 : ey);
                chk("fail_low", fail, 0);
                chk("busy_low", busy, 0);
                done = 1;
            end else if (mode == 0 && q >= MT) begin
                for (int i = 0; i < 5 && busy; i++) tick();
                chk("exhaust_fail", fail, 1);
                chk("exhaust_fv", food_valid, 0);
                chk("exhaust_busy", busy, 0);
                done = 1;
            end else begin
                rx = int'($urandom_range(0, 1023));
                ry = int'($urandom_range(0, 1023));
                rnd_x = 10'(rx); rnd_y = 10'(ry);
                ex = rx % W; ey = ry % H;
                exp_lat = max2(rx / W, ry / H) + 2;
                cyc = 0;
            end
        end
        if (mode == 0) chk("query_count", q, (nhits < MT) ? nhits + 1 : MT);
        if (pulse_busy) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("no_second_place", {busy, occ_req}, 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        place(100, 50, 0, 0, 0, 0);
        place(31, 24, 0, 0, 0, 0);
        place(1023, 1023, 0, 0, 0, 0);
        place(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1, 0, 0, 0);
        place(200, 300, 0, 4, 0, 1);
`ifdef FOOD_PLACER_SCAN_EN
        place(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0, 0, 1, 0);
`else
        place(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), MT, 0, 0, 0);
`endif
        for (int i = 0; i < 20; i++)
            place(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0);

        // Reset mid-REDUCE (n = 42 reduction steps pending).
        rnd_x = 10'd1023; rnd_y = 10'd1023; req = 1'b1;
        tick();
        req = 1'b0;
        tick(); tick();
        chk("mid_reduce_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_reduce");
        tick();
        rst_n = 1'b1;
        tick();
        place(100, 50, 0, 0, 0, 0);

        // Reset mid-QUERY while waiting for an ack.
        rnd_x = 10'd5; rnd_y = 10'd7; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        chk("mid_query_req", occ_req, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_query");
        tick();
        rst_n = 1'b1;
        tick();
        place(31, 24, 0, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/food_placer.md
# food_placer

Turns the free-running pseudo-random X/Y words from the coordinate LFSR into a legal food cell on the snake playfield. On request, it samples the two 10-bit random words and reduces them modulo the grid size. It then asks the snake body store whether the cell is occupied and retries until it finds a free cell. It sits between the LFSR and the game controller/renderer, and its `food_x`/`food_y` registers are the authoritative food position.

## Interface
- `GRID_W`, 32: playfield width in cells, 2..64
- `GRID_H`, 24: playfield height in cells, 2..64
- `MAX_TRIES`, 15: maximum number of random candidates per request, 1..15
- `clk1` input 1: clock; the LFSR X word advances on this clock
- `rst_n` input 1: reset, asynchronous, active-low
- `req` input 1: place-food request, level-sampled; accepted only in IDLE
- `rnd_x` input 10: random X word from the LFSR
- `rnd_y` input 10: random Y word from the LFSR
- `occ_req` output 1: occupancy query valid
- `occ_x` output 6: queried cell column
- `occ_y` output 6: queried cell row
- `occ_ack` input 1: query answered this cycle
- `occ_hit` input 1: cell occupied; valid only when `occ_ack`=1
- `food_x` output 6: placed food column
- `food_y` output 6: placed food row
- `food_valid` output 1: `food_x`/`food_y` hold a placed cell
- `fail` output 1: no free cell found for the last request
- `busy` output 1: a request is in progress (state is not IDLE)

## Operation
- Reset values: every output is 0; state is IDLE; the try counter is 0.
- IDLE
  - If `req`=1: latch `rnd_x`→sx and `rnd_y`→sy (10 bits each).
  - Clear `food_valid` and `fail`; set tries=0.
  - Go to REDUCE.
- REDUCE: one subtraction step per cycle, X and Y in parallel.
  - If sx≥GRID_W, then sx−=GRID_W; if sy≥GRID_H, then sy−=GRID_H.
  - Once both are in range (checked before subtracting), go to QUERY.
  - Use unsigned compare/subtract only; the result is the exact modulo.
- QUERY
  - Drive `occ_req`=1, `occ_x`=sx[5:0], `occ_y`=sy[5:0`]`; hold all three stable until `occ_ack`.
  - On `occ_ack` with `occ_hit`=0: `food_x`/`food_y`←sx/sy, `food_valid`←1, go to IDLE.
  - On `occ_ack` with `occ_hit`=1: tries+=1.
    - If tries<MAX_TRIES: go to RESAMPLE.
    - Otherwise: go to FAIL, or to SCAN when the macro is enabled.
- RESAMPLE: latch `rnd_x`/`rnd_y` again (the LFSR has advanced), go to REDUCE.
- FAIL: `fail`←1, `food_valid` stays 0, go to IDLE.
- `food_valid` and `fail` are levels held until the next accepted `req`. They are never both 1.
- `req` while `busy`=1 is ignored and is not queued.
- `occ_ack` outside QUERY/SCAN is ignored.
- Reset mid-operation aborts immediately; all outputs return to their reset values.

## Timing
- `req` is sampled high at edge k.
- REDUCE costs n+1 edges, where n = max(⌊rnd_x/GRID_W⌋, ⌊rnd_y/GRID_H⌋).
- `occ_req` rises after edge k+1+n.
- Ack at the first `occ_req` cycle with no hit: `food_valid` rises after edge k+2+n.
- Each retry adds 1 (RESAMPLE) + n' + query wait.
- `occ_req` drops in the cycle after the ack edge; there is no back-to-back query without a state step.
- `busy` is high from edge k+1 until the edge entering IDLE.

## Configuration
- `FOOD_PLACER_SCAN_EN` defined: after MAX_TRIES hits, enter SCAN.
  - Start at the last candidate and advance x+1; x wraps to 0 at GRID_W with y+1; y wraps to 0 at GRID_H.
  - Query each cell with the same handshake.
  - The first free cell is placed.
  - If all GRID_W×GRID_H cells have been queried and all hit, go to FAIL.
- Not defined: SCAN does not exist; MAX_TRIES hits go directly to FAIL.

## Test plan
- Reduction: `rnd_x`=100, `rnd_y`=50, acks with no hit → query (4,2), `food_x`=4, `food_y`=2, `food_valid`=1, 3 REDUCE subtractions.
- Boundaries: `rnd_x`=31, `rnd_y`=24 → cell (31,0). `rnd_x`=1023, `rnd_y`=1023 → cell (31,15). Zero-wait ack gives latency k+2+n exactly.
- Retry: first query hits, second misses → exactly 2 `occ_req` handshakes; food = second reduced sample; `fail`=0.
- Exhaustion (macro off): `occ_hit` tied 1 → exactly 15 queries, then `fail`=1, `food_valid`=0, `busy`=0. Macro on, with only cell (5,3) free → `food_x`=5, `food_y`=3.
- Handshake hold: delay `occ_ack` 4 cycles → `occ_x`/`occ_y`/`occ_req` stable throughout. A `req` pulse during busy → no second placement.
- Reset mid-REDUCE and mid-QUERY → all outputs 0 the same cycle; next `req` completes normally.
